// File: rtl/gate_array_pipe_if.sv
// Valid/ready stream bundle for gate_array_pipe: lane input side and reduced result side.
// slave is the pipeline's view; master is the source/sink environment's view.
interface gate_array_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_IN*WIDTH-1:0]   in_data;
  logic [2:0]                op;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;

  modport slave (
    input  in_valid, in_data, op, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, op, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/gate_array_pipe.sv
// NUM_IN-lane bitwise reduction with run-time op select, STAGES-deep valid/ready pipeline
// and a saturating count of bits flipped between successive delivered results.
module gate_array_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  gate_array_pipe_if.slave bus,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             busy
);

  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]  and_r;
  logic [WIDTH-1:0]  or_r;
  logic [WIDTH-1:0]  xor_r;
  logic [WIDTH-1:0]  lane0;
  logic [WIDTH-1:0]  red;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] stage_rdy;
  logic [WIDTH-1:0]  data [STAGES];

  logic [WIDTH-1:0]  last;
  logic [WIDTH-1:0]  diff;
  logic [PC_W-1:0]   pc;
  logic [SUM_W-1:0]  sum;
  logic              out_xfer;

  assign lane0 = bus.in_data[WIDTH-1:0];

  always_comb begin
    and_r = '1;
    or_r  = '0;
    xor_r = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      and_r = and_r & bus.in_data[k*WIDTH +: WIDTH];
      or_r  = or_r  | bus.in_data[k*WIDTH +: WIDTH];
      xor_r = xor_r ^ bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    red = and_r;
    case (bus.op)
      3'd0: red = and_r;
      3'd1: red = or_r;
      3'd2: red = xor_r;
      3'd3: red = ~and_r;
      3'd4: red = ~or_r;
      3'd5: red = ~xor_r;
      3'd6: red = ~lane0;
      3'd7: red = lane0;
      default: red = and_r;
    endcase
  end

  // Ready ripples back from the sink; a stage accepts when empty or being drained.
  always_comb begin
    logic rdy;
    rdy = bus.out_ready;
    stage_rdy = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      rdy = !vld[i] | rdy;
      stage_rdy[i] = rdy;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) data[i] <= '0;
    end else begin
      if (stage_rdy[0]) begin
        vld[0] <= bus.in_valid;
        if (bus.in_valid) data[0] <= red;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (stage_rdy[i]) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) data[i] <= data[i-1];
        end
      end
    end
  end

  assign bus.in_ready  = stage_rdy[0];
  assign bus.out_valid = vld[STAGES-1];
  assign bus.out_data  = data[STAGES-1];
  assign busy          = |vld;
  assign out_xfer      = vld[STAGES-1] & bus.out_ready;

  assign diff = data[STAGES-1] ^ last;

  always_comb begin
    pc = '0;
    for (int b = 0; b < WIDTH; b++) pc = pc + PC_W'(diff[b]);
  end

  assign sum = SUM_W'(toggle_cnt) + SUM_W'(pc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last       <= '0;
      toggle_cnt <= '0;
    end else if (out_xfer) begin
      last       <= data[STAGES-1];
      toggle_cnt <= (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    end
  end

endmodule

// File: doc/gate_array_pipe.md
Name: gate_array_pipe

Overview:
- Parametrised, pipelined successor to the two-input gate: NUM_IN lanes of WIDTH bits reduced bitwise by a run-time selectable logic operation.
- Result passes through STAGES register stages with a valid/ready handshake at both ends.
- Includes a saturating output-toggle counter for switching-activity measurement.
- Sits between a stimulus source and a sink or checker in unit-level gate experiments.

Parameters:
- WIDTH, 8, bit width of each input lane and of the result (1..32)
- NUM_IN, 2, number of input lanes reduced per beat (2..8)
- STAGES, 2, pipeline register stages from input acceptance to out_data (1..8)
- CNT_W, 16, width of the toggle counter

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- in_valid  in  1  upstream beat present
- in_ready  out  1  block can accept a beat this cycle
- in_data  in  NUM_IN*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH]
- op  in  3  operation, sampled with the beat: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT lane0, 7 BUF lane0
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts the beat
- out_data  out  WIDTH  reduced result
- toggle_cnt  out  CNT_W  total bits flipped between successive delivered beats
- busy  out  1  any pipeline stage holds a valid beat

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All stage valid bits = 0, all stage data = 0.
  - out_valid=0, out_data=0, toggle_cnt=0, last-delivered register=0, busy=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards every in-flight beat; no partial delivery afterwards.
- Transfers: a transfer occurs when valid & ready are both high at a clk edge. Input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Reduction: combinational on in_data and op at acceptance.
  - Result is written into stage 1 together with valid=1.
  - op is not stored; a beat's result is fixed at acceptance, and later op changes never affect it.
  - NAND/NOR/XNOR are the bitwise inversion of the AND/OR/XOR reduction over all NUM_IN lanes.
- Stage advance:
  - Stage k (1..STAGES) loads from stage k-1 when stage k is empty or stage k is being emptied this cycle.
  - stage_ready[k] = !valid[k] | stage_ready[k+1]; stage_ready[STAGES+1] = out_ready.
  - in_ready = stage_ready[1]; this is the only combinational in->out path, with no dependence on in_valid.
- Latency and throughput:
  - With out_ready held high, a beat accepted at edge N is presented with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles including acceptance.
  - Throughput is 1 beat/cycle.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
  - The pipeline fills; in_ready drops once all STAGES are valid.
  - No beat is lost or duplicated.
- Toggle counter: on each output transfer:
  - toggle_cnt += popcount(out_data ^ last), then last <= out_data.
  - The first beat after reset compares against 0.
  - Saturates at 2^CNT_W-1 and never wraps.
- busy = OR of all stage valid bits.
- Simultaneous input and output transfer with a full pipeline: allowed, occupancy unchanged.

Test Plan:
- Reset then single beat: WIDTH=8, NUM_IN=2, op=0, lanes 0xF0/0x3C -> out_data=0x30 with out_valid exactly STAGES cycles after acceptance; toggle_cnt=2.
- All ops sweep: lanes 0xAA/0x0F, op 0..7 back-to-back, out_ready=1 -> outputs 0x0A,0xAF,0xA5,0xF5,0x50,0x5A,0x55,0xAA on consecutive cycles, one per cycle.
- Backpressure: stream 6 beats, out_ready=0 for 5 cycles -> in_ready=0 once STAGES beats are held; out_data stable; all 6 delivered in order after release.
- Op change after acceptance: accept AND beat, switch op to OR next cycle -> delivered value is the AND result.
- Counter saturation: CNT_W=4, alternate 0x00/0xFF beats -> toggle_cnt reads 8, then 15, and stays at 15.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight -> next cycle out_valid=0, busy=0, toggle_cnt=0; those beats are never delivered.
